// File: rtl/display_scan_driver_if.sv
// Connection between a display controller and the 7-segment scan driver.
// The controller side drives the value and options; the driver side returns the scan outputs.
interface display_scan_driver_if #(
   parameter int N_DIGITS = 4
);
   logic                  load;
   logic [4*N_DIGITS-1:0] data_in;
   logic                  blank_lz;
   logic [3:0]            digit_val;
   logic [N_DIGITS-1:0]   digit_en;
   logic                  digit_blank;
   logic                  frame_done;

   modport master (
      output load, data_in, blank_lz,
      input  digit_val, digit_en, digit_blank, frame_done
   );

   modport slave (
      input  load, data_in, blank_lz,
      output digit_val, digit_en, digit_blank, frame_done
   );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexed scan driver for common-anode 7-segment digits: one nibble per slot,
// double-buffered value committed at frame wrap, leading-zero blanking and a dead cycle per slot.
module display_scan_driver #(
   parameter int CLK_DIV  = 50000,
   parameter int N_DIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   display_scan_driver_if.slave bus
);
   localparam int DW    = 4 * N_DIGITS;
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DW-1:0]       disp_q, disp_d;
   logic [DW-1:0]       pend_data_q, pend_data_d;
   logic                pend_q, pend_d;
   logic [N_DIGITS-1:0] digit_en_q, digit_en_d;
   logic [3:0]          digit_val_q, digit_val_d;
   logic                digit_blank_q, digit_blank_d;
   logic                frame_done_q, frame_done_d;

   logic                tick;
   logic                wrap;
   logic [3:0]          nib_next [N_DIGITS];
   logic [N_DIGITS-1:0] lz_blank;
   logic                zero_run;

   assign tick = (cnt_q == CNT_LAST);
   assign wrap = tick && (idx_q == IDX_LAST);

   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
         assign nib_next[gi] = disp_d[4*gi +: 4];
      end
   endgenerate

   // Blank flags are derived from the value that will be displayed after this edge,
   // so a wrap-edge commit is already reflected in the first slot of the new frame.
   always_comb begin
      lz_blank = '0;
      zero_run = 1'b1;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         zero_run    = zero_run && (disp_d[4*k +: 4] == 4'h0);
         lz_blank[k] = bus.blank_lz && zero_run;
      end
   end

   // Prescaler, digit index and double buffer.
   always_comb begin
      cnt_d       = cnt_q + CNT_W'(1);
      idx_d       = idx_q;
      disp_d      = disp_q;
      pend_data_d = pend_data_q;
      pend_d      = pend_q;

      if (tick) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end

      if (wrap) begin
         pend_d = 1'b0;
         if (bus.load) begin
            disp_d = bus.data_in;
         end else if (pend_q) begin
            disp_d = pend_data_q;
         end
      end else if (bus.load) begin
         pend_data_d = bus.data_in;
         pend_d      = 1'b1;
      end
   end

   // Scan outputs: enables go dark on the tick edge, then light the current digit unless blanked.
   always_comb begin
      digit_en_d    = digit_en_q;
      digit_val_d   = digit_val_q;
      digit_blank_d = digit_blank_q;
      frame_done_d  = wrap;

      if (tick) begin
         digit_en_d    = '1;
         digit_val_d   = nib_next[idx_d];
         digit_blank_d = lz_blank[idx_d];
      end else if (digit_blank_q) begin
         digit_en_d = '1;
      end else begin
         digit_en_d = ~(N_DIGITS'(1) << idx_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         disp_q        <= '0;
         pend_data_q   <= '0;
         pend_q        <= 1'b0;
         digit_en_q    <= '1;
         digit_val_q   <= 4'h0;
         digit_blank_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         disp_q        <= disp_d;
         pend_data_q   <= pend_data_d;
         pend_q        <= pend_d;
         digit_en_q    <= digit_en_d;
         digit_val_q   <= digit_val_d;
         digit_blank_q <= digit_blank_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign bus.digit_en    = digit_en_q;
   assign bus.digit_val   = digit_val_q;
   assign bus.digit_blank = digit_blank_q;
   assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized and directed bench for display_scan_driver; expected outputs come from an
// edge-count model (slot = edge/CLK_DIV, frame wrap every N_DIGITS*CLK_DIV edges).
module tb_display_scan_driver;
   localparam int CLK_DIV  = 4;
   localparam int N_DIGITS = 4;
   localparam int FRAME    = CLK_DIV * N_DIGITS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   display_scan_driver_if #(.N_DIGITS(N_DIGITS)) bus ();

   display_scan_driver #(
      .CLK_DIV  (CLK_DIV),
      .N_DIGITS (N_DIGITS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model state: edges since reset release, shown value, pending buffer, blank_lz seen at last tick.
   int          e;
   logic [15:0] m_disp;
   logic [15:0] m_pendv;
   bit          m_pend;
   bit          m_blz;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
      end
   endtask

   task automatic model_reset();
      e       = 0;
      m_disp  = 16'h0;
      m_pendv = 16'h0;
      m_pend  = 1'b0;
      m_blz   = 1'b0;
   endtask

   function automatic bit m_blanked(input int k);
      if (!m_blz || k == 0) return 1'b0;
      return (m_disp >> (4 * k)) == 16'h0;
   endfunction

   task automatic check_outputs();
      int          k;
      bit          b;
      logic [3:0]  one;
      logic [3:0]  exp_en;
      logic [15:0] sh;
      one = 4'b0001;
      k   = (e / CLK_DIV) % N_DIGITS;
      b   = m_blanked(k);
      if ((e % CLK_DIV) == 0 || b) exp_en = 4'hF;
      else                         exp_en = ~(one << k);
      sh = m_disp >> (4 * k);
      check_val("digit_en",    32'(bus.digit_en),    32'(exp_en));
      check_val("digit_val",   32'(bus.digit_val),   32'(sh[3:0]));
      check_val("digit_blank", 32'(bus.digit_blank), 32'(b));
      check_val("frame_done",  32'(bus.frame_done),  32'(e != 0 && (e % FRAME) == 0));
   endtask

   // One clock edge: update the model from the inputs seen at the edge, then check outputs.
   task automatic step();
      logic        ld;
      logic [15:0] d;
      logic        bl;
      @(posedge clk);
      ld = bus.load;
      d  = bus.data_in;
      bl = bus.blank_lz;
      if (!rst_n) begin
         model_reset();
      end else begin
         e++;
         if ((e % FRAME) == 0) begin
            if (ld)          m_disp = d;
            else if (m_pend) m_disp = m_pendv;
            m_pend = 1'b0;
         end else if (ld) begin
            m_pend  = 1'b1;
            m_pendv = d;
         end
         if ((e % CLK_DIV) == 0) m_blz = bl;
      end
      #1;
      check_outputs();
   endtask

   task automatic do_load(input logic [15:0] d);
      bus.load    = 1'b1;
      bus.data_in = d;
      step();
      $display("load data=%h edge=%0d wrap=%0d blank_lz=%0d", d, e, (e % FRAME) == 0, bus.blank_lz);
      bus.load = 1'b0;
   endtask

   initial begin
      bus.load     = 1'b0;
      bus.data_in  = 16'h0;
      bus.blank_lz = 1'b0;
      model_reset();

      // Reset held with the clock running.
      repeat (3) step();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) step();

      // Mid-frame load shows only after the wrap.
      do_load(16'h1234);
      repeat (2 * FRAME) step();

      // Leading-zero suppression.
      bus.blank_lz = 1'b1;
      do_load(16'h0050);
      repeat (2 * FRAME) step();
      do_load(16'h0000);
      repeat (2 * FRAME) step();
      bus.blank_lz = 1'b0;

      // Two loads in one frame: last value wins.
      while ((e % FRAME) != 1) step();
      do_load(16'hAAAA);
      repeat (3) step();
      do_load(16'hBBBB);
      repeat (2 * FRAME) step();

      // Load on the wrap edge is visible on that edge.
      while (((e + 1) % FRAME) != 0) step();
      do_load(16'hF00D);
      check_val("wrap_load_val", 32'(bus.digit_val), 32'h0000_000D);
      repeat (FRAME + 2) step();

      // Free run.
      repeat (3 * FRAME) step();

      // Asynchronous reset mid-slot discards pending data.
      while ((e % FRAME) != 1) step();
      do_load(16'h5A5A);
      while (!((e % CLK_DIV) == 2 && ((e / CLK_DIV) % N_DIGITS) == 3)) step();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_en",    32'(bus.digit_en),    32'h0000_000F);
      check_val("async_rst_val",   32'(bus.digit_val),   32'h0);
      check_val("async_rst_blank", 32'(bus.digit_blank), 32'h0);
      check_val("async_rst_fd",    32'(bus.frame_done),  32'h0);
      model_reset();
      repeat (3) step();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * FRAME) step();

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         bus.load = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0:       bus.data_in = 16'($urandom);
            1:       bus.data_in = 16'($urandom & 32'h00FF);
            2:       bus.data_in = 16'($urandom & 32'h000F);
            default: bus.data_in = 16'h0;
         endcase
         if ($urandom_range(0, 40) == 0) bus.blank_lz = ~bus.blank_lz;
         step();
         if (bus.load && (e % FRAME) == 0)
            $display("load data=%h edge=%0d wrap=1 (random)", bus.data_in, e);
      end
      bus.load = 1'b0;
      repeat (FRAME) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
